sprite_table: RTL and testbench

//  Double-buffered sprite attribute table feeding the sprite mappers' sprite_info inputs.

---
 rtl/sprite_table.sv | 167 ++++++++++++++++
 tb/tb_sprite_table.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_table.sv
`default_nettype none
// ============================================================================
// Module      : sprite_table
// Description : Double-buffered sprite attribute table. Game logic edits a
//               shadow bank of {en, X[9:0], Y[8:0]} entries and commits the
//               frame. On the next vertical-sync falling edge the shadow bank
//               is copied into the active bank, which drives every sprite
//               mapper, so on-screen sprites never tear mid-frame.
// Ports       : Clk          - system clock
//               Reset        - synchronous, active-high reset
//               vs           - VGA vertical sync (active-low); frame boundary
//                              is its falling edge
//               wr_valid     - write request
//               wr_ready     - table accepts a write this cycle
//               wr_idx       - entry to write (out-of-range writes dropped)
//               wr_data      - [19]=en, [18:9]=X, [8:0]=Y
//               clr_all      - clear en bit of every shadow entry
//               commit       - shadow frame complete, swap at next boundary
//               committed    - high from accepted commit until swap completes
//               swap_done    - 1-cycle pulse after the active bank updates
//               sprite_bus   - active bank, entry i at [20*i+19 : 20*i]
//               active_count - number of active entries with en=1
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_table #(
    parameter int NUM_SPRITES = 16,
    parameter int IDX_W       = $clog2(NUM_SPRITES),
    parameter int CNT_W       = $clog2(NUM_SPRITES + 1)
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      vs,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [19:0]               wr_data,
    input  logic                      clr_all,
    input  logic                      commit,
    output logic                      committed,
    output logic                      swap_done,
    output logic [NUM_SPRITES*20-1:0] sprite_bus,
    output logic [CNT_W-1:0]          active_count
);

    localparam logic [1:0] c_ST_OPEN      = 2'd0;
    localparam logic [1:0] c_ST_COMMITTED = 2'd1;
    localparam logic [1:0] c_ST_SWAP      = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_vs_q;
    logic             w_fall;
    logic             w_open;
    logic             r_committed;
    logic             r_swap_done;
    logic [19:0]      r_shadow [NUM_SPRITES];
    logic [19:0]      r_active [NUM_SPRITES];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_shadow_count;

    // vs is registered once; the boundary is the cycle where the previous
    // sample was high and the current one is low.
    assign w_fall   = r_vs_q & ~vs;
    assign w_open   = (r_state == c_ST_OPEN);
    assign wr_ready = w_open;

    // ------------------------------------------------------------------
    // Frame-swap state machine
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_ST_OPEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_OPEN:      if (commit) w_state_next = c_ST_COMMITTED;
            c_ST_COMMITTED: if (w_fall) w_state_next = c_ST_SWAP;
            c_ST_SWAP:      w_state_next = c_ST_OPEN;
            default:        w_state_next = c_ST_OPEN;
        endcase
    end

    // ------------------------------------------------------------------
    // Edge register and registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_vs_q      <= 1'b1;
            r_committed <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_vs_q      <= vs;
            r_swap_done <= (r_state == c_ST_SWAP);
            if (w_open && commit) begin
                r_committed <= 1'b1;
            end else if (r_state == c_ST_SWAP) begin
                r_committed <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow bank. The clear is written first and the indexed write second,
    // so when both happen in the same cycle the later non-blocking
    // assignment wins and the written entry keeps its own en bit. Indices
    // at or beyond NUM_SPRITES match no entry and are silently dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_open) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (clr_all) begin
                    r_shadow[i][19] <= 1'b0;
                end
                if (wr_valid && (wr_idx == IDX_W'(i))) begin
                    r_shadow[i] <= wr_data;
                end
            end
        end
    end

    // Population count of shadow en bits, captured alongside the bank copy
    // so sprite_bus and active_count always describe the same frame.
    always_comb begin
        w_shadow_count = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_shadow_count = w_shadow_count + CNT_W'(r_shadow[i][19]);
        end
    end

    // ------------------------------------------------------------------
    // Active bank: only updated during the single SWAP cycle
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_active[i] <= '0;
            end
            r_count <= '0;
        end else if (r_state == c_ST_SWAP) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_active[i] <= r_shadow[i];
            end
            r_count <= w_shadow_count;
        end
    end

    generate
        for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_bus
            assign sprite_bus[20*g +: 20] = r_active[g];
        end
    endgenerate

    assign committed    = r_committed;
    assign swap_done    = r_swap_done;
    assign active_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sprite_table.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_table
// Description : Self-checking bench for sprite_table. Two instances share the
//               stimulus: a 16-entry table and a 12-entry table (so a 4-bit
//               index can address beyond the table). A frame-level reference
//               model holds shadow/active banks as plain arrays and is
//               compared against both instances every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vs;
    logic        wr_valid;
    logic [3:0]  wr_idx;
    logic [19:0] wr_data;
    logic        clr_all;
    logic        commit;

    logic         wr_ready16, committed16, swap_done16;
    logic [319:0] bus16;
    logic [4:0]   cnt16;
    logic         wr_ready12, committed12, swap_done12;
    logic [239:0] bus12;
    logic [3:0]   cnt12;

    sprite_table u_dut16 (
        .Clk(clk), .Reset(rst), .vs(vs), .wr_valid(wr_valid), .wr_ready(wr_ready16),
        .wr_idx(wr_idx), .wr_data(wr_data), .clr_all(clr_all), .commit(commit),
        .committed(committed16), .swap_done(swap_done16),
        .sprite_bus(bus16), .active_count(cnt16)
    );

    sprite_table #(.NUM_SPRITES(12)) u_dut12 (
        .Clk(clk), .Reset(rst), .vs(vs), .wr_valid(wr_valid), .wr_ready(wr_ready12),
        .wr_idx(wr_idx), .wr_data(wr_data), .clr_all(clr_all), .commit(commit),
        .committed(committed12), .swap_done(swap_done12),
        .sprite_bus(bus12), .active_count(cnt12)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_done16 = 0;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Frame phase: 0 = editing, 1 = waiting for boundary,
    // 2 = copying shadow into active.
    // ------------------------------------------------------------------
    logic [19:0] m_shadow [2][16];
    logic [19:0] m_active [2][16];
    int          m_count  [2];
    int          m_size   [2] = '{16, 12};
    int          m_phase  = 0;
    bit          m_vsq    = 1'b1;
    bit          m_done   = 1'b0;

    function automatic logic [319:0] m_bus(input int d);
        logic [319:0] b;
        b = '0;
        for (int i = 0; i < m_size[d]; i++) b[20*i +: 20] = m_active[d][i];
        return b;
    endfunction

    task automatic model_step();
        bit fall;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 16; i++) begin
                    m_shadow[d][i] = '0;
                    m_active[d][i] = '0;
                end
                m_count[d] = 0;
            end
            m_phase = 0;
            m_vsq   = 1'b1;
            m_done  = 1'b0;
        end else begin
            fall   = m_vsq && !vs;
            m_vsq  = vs;
            m_done = (m_phase == 2);
            if (m_phase == 0) begin
                for (int d = 0; d < 2; d++) begin
                    if (clr_all)
                        for (int i = 0; i < m_size[d]; i++) m_shadow[d][i][19] = 1'b0;
                    if (wr_valid && (int'(wr_idx) < m_size[d]))
                        m_shadow[d][wr_idx] = wr_data;
                end
                if (commit) m_phase = 1;
            end else if (m_phase == 1) begin
                if (fall) m_phase = 2;
            end else begin
                for (int d = 0; d < 2; d++) begin
                    m_count[d] = 0;
                    for (int i = 0; i < m_size[d]; i++) begin
                        m_active[d][i] = m_shadow[d][i];
                        m_count[d] += int'(m_shadow[d][i][19]);
                    end
                end
                m_phase = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("wr_ready16",  320'(wr_ready16),  320'(m_phase == 0));
        chk("committed16", 320'(committed16), 320'(m_phase != 0));
        chk("swap_done16", 320'(swap_done16), 320'(m_done));
        chk("bus16",       bus16,             m_bus(0));
        chk("count16",     320'(cnt16),       320'(m_count[0]));
        chk("wr_ready12",  320'(wr_ready12),  320'(m_phase == 0));
        chk("committed12", 320'(committed12), 320'(m_phase != 0));
        chk("swap_done12", 320'(swap_done12), 320'(m_done));
        chk("bus12",       320'(bus12),       m_bus(1));
        chk("count12",     320'(cnt12),       320'(m_count[1]));
    endtask

    // One clock: model consumes the applied inputs, DUT sampled 1ns after edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        n_done16 += int'(swap_done16);
        check_all();
    endtask

    task automatic idle();
        rst = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_data = '0;
        clr_all = 1'b0; commit = 1'b0;
    endtask

    task automatic write(input logic [3:0] idx, input logic [19:0] data);
        wr_valid = 1'b1; wr_idx = idx; wr_data = data;
        cycle();
        wr_valid = 1'b0;
    endtask

    // Commit, then a vs falling edge; the bank is visible two clocks after vs low.
    task automatic commit_and_swap();
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        vs = 1'b0;
        cycle();
        cycle();
        vs = 1'b1;
        cycle();
    endtask

    logic [319:0] saved16;
    logic [319:0] saved12;

    initial begin
        idle();
        vs  = 1'b1;
        rst = 1'b1;
        #1;

        // Reset held two clocks
        cycle();
        cycle();
        rst = 1'b0;
        chk("t1_bus",       bus16,        '0);
        chk("t1_count",     320'(cnt16),  '0);
        chk("t1_wr_ready",  320'(wr_ready16), 320'(1));
        chk("t1_committed", 320'(committed16), '0);

        // Basic write, commit, swap
        write(4'd3, 20'hFC850);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        chk("t2_committed", 320'(committed16), 320'(1));
        n_done16 = 0;
        vs = 1'b0;
        cycle();
        cycle();
        chk("t2_entry3", 320'(bus16[79:60]), 320'(20'hFC850));
        chk("t2_count",  320'(cnt16), 320'(1));
        vs = 1'b1;
        cycle();
        cycle();
        chk("t2_done_pulses", 320'(n_done16), 320'(1));

        // Boundary with no commit leaves the active bank alone
        write(4'd3, 20'h12345);
        vs = 1'b0;
        cycle();
        cycle();
        vs = 1'b1;
        cycle();
        chk("t3_entry3",   320'(bus16[79:60]), 320'(20'hFC850));
        chk("t3_wr_ready", 320'(wr_ready16), 320'(1));

        // Writes are refused while committed
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        chk("t4_wr_ready", 320'(wr_ready16), '0);
        write(4'd5, 20'h80001);
        vs = 1'b0;
        cycle();
        cycle();
        vs = 1'b1;
        cycle();
        chk("t4_entry5_blocked", 320'(bus16[119:100]), '0);
        chk("t4_entry3_swapped", 320'(bus16[79:60]), 320'(20'h12345));
        write(4'd5, 20'h80001);
        commit_and_swap();
        chk("t4_entry5_ok", 320'(bus16[119:100]), 320'(20'h80001));

        // Fill all, then clear + write in the same cycle
        for (int i = 0; i < 16; i++) write(4'(i), {1'b1, 19'(i * 12345 + 7)});
        commit_and_swap();
        chk("t5_full_count", 320'(cnt16), 320'(16));
        clr_all = 1'b1;
        write(4'd0, 20'h80000);
        clr_all = 1'b0;
        commit_and_swap();
        chk("t5_clr_count", 320'(cnt16), 320'(1));
        chk("t5_entry0",    320'(bus16[19:0]), 320'(20'h80000));
        chk("t5_entry7",    320'(bus16[159:140]), 320'({1'b0, 19'(7 * 12345 + 7)}));

        // Out-of-range index on the 12-entry table
        saved12 = 320'(bus12);
        chk("t6_ready_oob", 320'(wr_ready12), 320'(1));
        write(4'hF, 20'hFFFFF);
        commit_and_swap();
        chk("t6_bus12_oob", 320'(bus12), saved12);
        chk("t6_entry15_16", 320'(bus16[319:300]), 320'(20'hFFFFF));

        // Reset while in the swap cycle
        write(4'd2, 20'hABCDE);
        commit = 1'b1;
        cycle();
        commit = 1'b0;
        vs = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vs = 1'b1;
        chk("t6_rst_bus",   bus16, '0);
        chk("t6_rst_count", 320'(cnt16), '0);
        chk("t6_rst_done",  320'(swap_done16), '0);
        chk("t6_rst_comm",  320'(committed16), '0);
        cycle();
        chk("t6_rst_done2", 320'(swap_done16), '0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            vs       = ($urandom_range(0, 5) != 0);
            wr_valid = ($urandom_range(0, 1) == 1);
            wr_idx   = 4'($urandom_range(0, 15));
            wr_data  = 20'($urandom);
            clr_all  = ($urandom_range(0, 15) == 0);
            commit   = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
